// File: rtl/dispatch_buf.sv
// Dispatch holding buffer: captures one compacted decode bundle and
// releases its oldest entries as ROB/IQ credits allow.
module dispatch_buf #(
   parameter int WIDTH   = 4,
   parameter int ENTRY_W = 64,
   parameter int CW      = $clog2(WIDTH + 1)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            flush,
   input  logic [WIDTH-1:0]                in_valid,
   input  logic [WIDTH-1:0][ENTRY_W-1:0]   in_entry,
   output logic                            in_ready,
   input  logic [CW-1:0]                   rob_free,
   input  logic [CW-1:0]                   iq_free,
   output logic [CW-1:0]                   out_count,
   output logic [WIDTH-1:0]                out_valid,
   output logic [WIDTH-1:0][ENTRY_W-1:0]   out_entry,
   output logic                            reserve,
   output logic [31:0]                     stall_cycles
);

   typedef enum logic {EMPTY, HOLD} state_t;

   localparam logic [CW-1:0] WMAX = CW'(WIDTH);

   state_t             state;
   logic [CW-1:0]      hc;
   logic [CW-1:0]      cnt;
   logic [CW-1:0]      cap_n;
   logic               capture;
   logic [ENTRY_W-1:0] ent [WIDTH];
   logic [ENTRY_W-1:0] shf [WIDTH];
   logic [ENTRY_W-1:0] cap [WIDTH];
   int                 n;

   always_comb begin
      cnt = hc;
      if (rob_free < cnt) cnt = rob_free;
      if (iq_free < cnt) cnt = iq_free;
      if (flush || reset) cnt = '0;
   end

   assign out_count = cnt;
   assign reserve   = (cnt != '0);
   assign in_ready  = !flush && !reset && (cnt == hc);
   assign capture   = in_ready && (in_valid != '0);

   always_comb begin
      out_valid = '0;
      out_entry = '0;
      for (int k = 0; k < WIDTH; k++) begin
         out_valid[k] = (k < int'(cnt));
         out_entry[k] = ent[k];
      end
   end

   // Survivors slide down by the number dispatched this cycle.
   always_comb begin
      for (int k = 0; k < WIDTH; k++) shf[k] = ent[k];
      for (int k = 0; k < WIDTH; k++)
         for (int j = 0; j < WIDTH; j++)
            if (j == k + int'(cnt)) shf[k] = ent[j];
   end

   // Sparse valid lanes pack into slots 0..n-1 in lane order.
   always_comb begin
      n = 0;
      for (int k = 0; k < WIDTH; k++) cap[k] = ent[k];
      for (int i = 0; i < WIDTH; i++) begin
         if (in_valid[i]) begin
            for (int j = 0; j < WIDTH; j++)
               if (j == n) cap[j] = in_entry[i];
            n = n + 1;
         end
      end
      cap_n = CW'(n);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= EMPTY;
         hc           <= '0;
         stall_cycles <= '0;
      end else if (flush) begin
         state <= EMPTY;
         hc    <= '0;
      end else begin
         if (state == HOLD && cnt < hc && stall_cycles != '1)
            stall_cycles <= stall_cycles + 32'd1;
         if (capture) begin
            hc    <= cap_n;
            state <= HOLD;
         end else begin
            hc    <= hc - cnt;
            state <= (hc == cnt) ? EMPTY : HOLD;
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int k = 0; k < WIDTH; k++)
         ent[k] <= capture ? cap[k] : shf[k];
   end

   a_credit : assert property (@(posedge clock) disable iff (reset)
      (rob_free <= WMAX) && (iq_free <= WMAX));

endmodule
